// File: rtl/sad_accum.sv
// Windowed sum-of-absolute-differences accumulator over BLOCK_LEN multi-channel pixel beats.
// Build option: define SAD_SATURATE_EN to clamp the accumulator and report out_sat (default wraps).
module sad_accum #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 3,
    parameter int BLOCK_LEN = 64,
    parameter int ACC_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [CHANNELS*WIDTH-1:0] in_a,
    input  logic [CHANNELS*WIDTH-1:0] in_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ACC_W-1:0]          out_sad,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int SUM_W = WIDTH + $clog2(CHANNELS);
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   diff_p1 [CHANNELS];
    logic               vld_p1;
    logic [ACC_W-1:0]   acc_p2;
    logic               sat_p2;
    logic [SUM_W-1:0]   chsum;
    logic [ACC_W:0]     sum_nxt;
    logic               accept;

    function automatic logic [WIDTH-1:0] absdiff(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Returns {clamped, sum}; the top bit only ever rises in the saturating build.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [SUM_W-1:0] s);
`ifdef SAD_SATURATE_EN
        logic [ACC_W:0] full;
        full = {1'b0, acc} + (ACC_W+1)'(s);
        if (full[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return full;
`else
        return {1'b0, acc + ACC_W'(s)};
`endif
    endfunction

    always_comb begin
        chsum = '0;
        for (int c = 0; c < CHANNELS; c++)
            chsum = chsum + SUM_W'(diff_p1[c]);
    end

    assign sum_nxt  = acc_add(acc_p2, chsum);
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) diff_p1[c] <= '0;
            acc_p2    <= '0;
            sat_p2    <= 1'b0;
            out_sad   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) diff_p1[c] <= '0;
            acc_p2    <= '0;
            sat_p2    <= 1'b0;
            out_sad   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // stage 1: per-channel absolute differences
            vld_p1 <= accept;
            if (accept)
                for (int c = 0; c < CHANNELS; c++)
                    diff_p1[c] <= absdiff(in_a[c*WIDTH +: WIDTH], in_b[c*WIDTH +: WIDTH]);

            // stage 2: accumulate, drain the final beat into the result, hold for the consumer
            case (state)
                ACCUM: begin
                    if (vld_p1) begin
                        acc_p2 <= sum_nxt[ACC_W-1:0];
                        sat_p2 <= sat_p2 | sum_nxt[ACC_W];
                    end
                    if (accept) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    out_sad   <= sum_nxt[ACC_W-1:0];
                    out_sat   <= sat_p2 | sum_nxt[ACC_W];
                    out_valid <= 1'b1;
                    acc_p2    <= '0;
                    sat_p2    <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
